// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter slice: source-index width and the
// rotating priority pick.
package rr_arb_pkg;

   localparam int MAX_REQ = 16;

   typedef struct packed {
      logic       vld;
      logic [3:0] idx;
   } pick_t;

   function automatic int src_w_f(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // First set bit at or after ptr, wrapping over the n live requesters.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vec,
                                     input logic [3:0] ptr, input int n);
      pick_t p;
      int    idx;
      p = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            idx = (int'(ptr) + k) % n;
            if (!p.vld && vec[idx]) begin
               p.vld = 1'b1;
               p.idx = 4'(idx);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/reg_slice_forward.sv
// Forward register slice: registered valid/data, ready passes through when the
// slot is empty or draining this cycle.
module reg_slice_forward #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_vld,
   output logic         s_rdy,
   input  logic [W-1:0] s_data,
   output logic         m_vld,
   input  logic         m_rdy,
   output logic [W-1:0] m_data
);

   logic         vld_q, vld_d;
   logic [W-1:0] data_q, data_d;

   assign s_rdy  = !vld_q || m_rdy;
   assign m_vld  = vld_q;
   assign m_data = data_q;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (s_vld && s_rdy) begin
         vld_d  = 1'b1;
         data_d = s_data;
      end else if (m_rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/rr_arb_slice.sv
// Packet-aware round-robin arbiter: once a requester starts a packet it holds
// the grant until its last beat is accepted, then priority rotates past it.
module rr_arb_slice
   import rr_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int PLD_WIDTH = 32,
   localparam int SRC_W     = src_w_f(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           s_vld,
   output logic [NUM_REQ-1:0]           s_rdy,
   input  logic [NUM_REQ*PLD_WIDTH-1:0] s_pld,
   input  logic [NUM_REQ-1:0]           s_last,
   output logic                         m_vld,
   input  logic                         m_rdy,
   output logic [PLD_WIDTH-1:0]         m_pld,
   output logic [SRC_W-1:0]             m_src,
   output logic                         m_last
);

   localparam int SLICE_W = PLD_WIDTH + SRC_W + 1;

   logic [SRC_W-1:0]     ptr_q, ptr_d;
   logic                 locked_q, locked_d;
   logic [SRC_W-1:0]     lock_src_q, lock_src_d;
   logic [MAX_REQ-1:0]   vec;
   pick_t                pick;
   logic [SRC_W-1:0]     grant;
   logic                 grant_valid;
   logic                 slot_free;
   logic                 accept;
   logic [SLICE_W-1:0]   slice_in, slice_out;

   always_comb begin
      vec = '0;
      vec[NUM_REQ-1:0] = s_vld;
      pick = rr_pick(vec, 4'(ptr_q), NUM_REQ);
      if (locked_q) begin
         grant       = lock_src_q;
         grant_valid = s_vld[lock_src_q];
      end else begin
         grant       = SRC_W'(pick.idx);
         grant_valid = pick.vld;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
      assign s_rdy[i] = grant_valid && slot_free && (int'(grant) == i);
   end

   assign accept   = grant_valid && slot_free;
   assign slice_in = {s_last[grant], grant, s_pld[int'(grant)*PLD_WIDTH +: PLD_WIDTH]};

   always_comb begin
      ptr_d      = ptr_q;
      locked_d   = locked_q;
      lock_src_d = lock_src_q;
      if (accept) begin
         if (s_last[grant]) begin
            locked_d = 1'b0;
            ptr_d    = SRC_W'((int'(grant) + 1) % NUM_REQ);
         end else begin
            locked_d   = 1'b1;
            lock_src_d = grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         locked_q   <= 1'b0;
         lock_src_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         locked_q   <= locked_d;
         lock_src_q <= lock_src_d;
      end
   end

   reg_slice_forward #(.W(SLICE_W)) u_out (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_vld  (grant_valid),
      .s_rdy  (slot_free),
      .s_data (slice_in),
      .m_vld  (m_vld),
      .m_rdy  (m_rdy),
      .m_data (slice_out)
   );

   assign {m_last, m_src, m_pld} = slice_out;

endmodule

// File: tb/tb_rr_arb_slice.sv
// Directed bench for rr_arb_slice: rotation, packet lock, backpressure, lock
// hold on a stalled requester, and asynchronous reset mid-packet.
module tb_rr_arb_slice;

   localparam int N = 4;
   localparam int PW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_vld, s_rdy, s_last;
   logic [N*PW-1:0] s_pld;
   logic            m_vld, m_rdy, m_last;
   logic [PW-1:0]   m_pld;
   logic [1:0]      m_src;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rr_arb_slice #(.NUM_REQ(N), .PLD_WIDTH(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_vld(s_vld), .s_rdy(s_rdy), .s_pld(s_pld), .s_last(s_last),
      .m_vld(m_vld), .m_rdy(m_rdy), .m_pld(m_pld), .m_src(m_src), .m_last(m_last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pld(input int i, input logic [PW-1:0] v);
      s_pld[i*PW +: PW] = v;
   endtask

   initial begin
      logic [PW-1:0] held;
      rst_n = 1'b0; s_vld = '0; s_last = '0; s_pld = '0; m_rdy = 1'b1;
      for (int i = 0; i < N; i++) set_pld(i, 32'h100 + i);
      #12;
      chk("rst_mvld", m_vld, 0);
      chk("rst_mpld", m_pld, 0);
      chk("rst_msrc", m_src, 0);
      chk("rst_mlast", m_last, 0);
      chk("rst_srdy", s_rdy, 0);
      tick();
      rst_n = 1'b1;

      // All requesters valid, single-beat packets: plain rotation.
      s_vld = 4'b1111; s_last = 4'b1111;
      #1;
      chk("rot_srdy0", s_rdy, 4'b0001);
      chk("rot_mvld_pre", m_vld, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("rot_vld%0d", k), m_vld, 1);
         chk($sformatf("rot_src%0d", k), m_src, k % 4);
         chk($sformatf("rot_pld%0d", k), m_pld, 32'h100 + (k % 4));
      end
      s_vld = '0;
      tick();
      chk("rot_drain", m_vld, 0);

      // Req 2 three-beat packet while req 0 stays valid; ptr is 1 here.
      s_vld = 4'b0101; s_last = 4'b0001;
      for (int b = 0; b < 3; b++) begin
         set_pld(2, 32'h2000 + b);
         if (b == 2) s_last[2] = 1'b1;
         #1;
         chk($sformatf("pkt_srdy%0d", b), s_rdy, 4'b0100);
         tick();
         chk($sformatf("pkt_src%0d", b), m_src, 2);
         chk($sformatf("pkt_pld%0d", b), m_pld, 32'h2000 + b);
         chk($sformatf("pkt_last%0d", b), m_last, b == 2);
      end
      s_vld = 4'b0001;
      tick();
      chk("pkt_after_src", m_src, 0);
      chk("pkt_after_pld", m_pld, 32'h100);

      // Backpressure: output held for 5 cycles, then drains and accepts same edge.
      set_pld(0, 32'hAAAA0001);
      tick();
      chk("bp_first", m_pld, 32'hAAAA0001);
      m_rdy = 1'b0;
      set_pld(0, 32'hBBBB0002);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_srdy%0d", c), s_rdy, 0);
         tick();
         chk($sformatf("bp_hold%0d", c), m_pld, 32'hAAAA0001);
         chk($sformatf("bp_vld%0d", c), m_vld, 1);
      end
      m_rdy = 1'b1;
      #1;
      chk("bp_release_srdy", s_rdy, 4'b0001);
      tick();
      chk("bp_new_pld", m_pld, 32'hBBBB0002);
      chk("bp_new_vld", m_vld, 1);
      s_vld = '0;
      tick();
      chk("bp_drain", m_vld, 0);

      // Lock on req 1 (ptr=1); req 1 goes idle, others must wait.
      s_vld = 4'b0010; s_last = 4'b0000; set_pld(1, 32'h11);
      tick();
      chk("lk_src", m_src, 1);
      chk("lk_last", m_last, 0);
      s_vld = 4'b1101; s_last = 4'b1101;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("lk_srdy%0d", c), s_rdy, 0);
         tick();
         chk($sformatf("lk_novld%0d", c), m_vld, 0);
      end
      s_vld = 4'b1111; s_last = 4'b1111; set_pld(1, 32'h12);
      #1;
      chk("lk_resume_srdy", s_rdy, 4'b0010);
      tick();
      chk("lk_resume_src", m_src, 1);
      chk("lk_resume_pld", m_pld, 32'h12);
      chk("lk_resume_last", m_last, 1);
      chk("lk_next_srdy", s_rdy, 4'b0100);
      s_vld = '0;
      tick();

      // Reset in the middle of a req 3 packet (ptr=2), with the beat held.
      s_vld = 4'b1000; s_last = 4'b0000; set_pld(3, 32'h33);
      tick();
      chk("rs_src3", m_src, 3);
      m_rdy = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_async_vld", m_vld, 0);
      chk("rs_async_src", m_src, 0);
      chk("rs_async_pld", m_pld, 0);
      chk("rs_srdy_in_rst", s_rdy, 4'b1000);
      tick();
      s_vld = 4'b1010; s_last = 4'b1111; m_rdy = 1'b1; set_pld(1, 32'h44);
      rst_n = 1'b1;
      #1;
      chk("rs_post_srdy", s_rdy, 4'b0010);
      tick();
      chk("rs_post_src", m_src, 1);
      chk("rs_post_pld", m_pld, 32'h44);
      s_vld = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: sim did not finish, want finish");
      $fatal(1);
   end

endmodule

// File: doc/rr_arb_slice.md
RR_ARB_SLICE -- requirements
Module: rr_arb_slice

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal 1..16).
REQ-002 SHALL have parameter PLD_WIDTH, default 32, payload width in bits.
REQ-003 SHALL have derived localparam SRC_W = max(1, clog2(NUM_REQ)).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_vld  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port s_rdy  output  NUM_REQ  per-requester beat ready.
REQ-008 SHALL have port s_pld  input  NUM_REQ*PLD_WIDTH  payloads; requester i at bits [i*PLD_WIDTH +: PLD_WIDTH].
REQ-009 SHALL have port s_last  input  NUM_REQ  per-requester end-of-packet marker.
REQ-010 SHALL have port m_vld  output  1  registered output valid.
REQ-011 SHALL have port m_rdy  input  1  downstream ready.
REQ-012 SHALL have port m_pld  output  PLD_WIDTH  registered payload.
REQ-013 SHALL have port m_src  output  SRC_W  registered index of the source requester.
REQ-014 SHALL have port m_last  output  1  registered end-of-packet marker.

Function
REQ-015 SHALL define slot_free = !m_vld || m_rdy (combinational).
REQ-016 SHALL define an accept on requester i as s_vld[i] && s_rdy[i]; at most one accept per cycle.
REQ-017 When unlocked, SHALL grant the lowest index i >= ptr with s_vld[i]=1, wrapping modulo NUM_REQ; no grant if all s_vld are 0.
REQ-018 When locked, SHALL grant only lock_src, regardless of other s_vld bits.
REQ-019 SHALL drive s_rdy[i] = (grant == i) && grant_valid && slot_free; all other bits 0; s_rdy SHALL NOT depend on s_pld or s_last.
REQ-020 On an accept, the next edge SHALL load m_vld=1, m_pld=s_pld[grant], m_src=grant, m_last=s_last[grant] (latency exactly 1 cycle).
REQ-021 With no accept and m_rdy=1, the next edge SHALL clear m_vld; m_pld/m_src/m_last hold.
REQ-022 With m_vld=1 and m_rdy=0, all output registers SHALL hold.
REQ-023 SHALL sustain one beat per cycle when m_rdy is held at 1 (accept and drain on the same edge).
REQ-024 Accepting a beat with s_last=0 SHALL set locked=1 and lock_src=grant.
REQ-025 Accepting a beat with s_last=1 SHALL clear locked and set ptr=(grant+1) mod NUM_REQ.
REQ-026 ptr and locked SHALL change only on an accept.
REQ-027 With NUM_REQ=1, m_src SHALL be constant 0 and lock behaviour SHALL still apply.
REQ-028 A requester deasserting s_vld mid-packet SHALL NOT release the lock; the arbiter waits.

Reset
REQ-029 rst_n low SHALL immediately force m_vld=0, m_pld=0, m_src=0, m_last=0, ptr=0, locked=0, lock_src=0.
REQ-030 Reset mid-packet SHALL discard the lock and any held beat; after release, arbitration restarts from requester 0.
REQ-031 While rst_n is low, s_rdy SHALL be 0 only if no s_vld is high; s_rdy is otherwise a combinational function of the reset-forced state per REQ-019.

Structure
REQ-032 A shared package rr_arb_pkg SHALL hold the function computing SRC_W and the round-robin pick function (vector, pointer -> index, valid).
REQ-033 The output register SHALL be one instance of sub-module reg_slice_forward, with PLD_WIDTH+SRC_W+1 bits carrying {m_last, m_src, m_pld}; the arbiter feeds its s_vld/s_pld and uses its s_rdy as slot_free.

Verification
REQ-034 After reset, s_vld=4'b1111, all s_last=1, m_rdy=1 -> m_src sequence 0,1,2,3,0, one beat per cycle, first m_vld one cycle after the first accept.
REQ-035 Req 2 sends 3 beats (last on 3rd), req 0 is valid throughout -> m_src=2,2,2 then 0; s_rdy[0]=0 during the packet.
REQ-036 m_vld=1, m_rdy=0 for 5 cycles with s_vld=4'b0001 -> s_rdy=0, m_pld stable; m_rdy=1 -> beat accepted the same cycle.
REQ-037 Lock on req 1 (beat with last=0 accepted), then s_vld[1]=0 for 4 cycles with others valid -> no accepts; req 1 resumes -> its beats pass.
REQ-038 Assert rst_n=0 mid-packet of req 3 -> outputs 0 asynchronously; after release with s_vld=4'b1010, the first grant is to req 1.
